// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_arb_pkg
// Brief   : Shared types and AXI3 constants for the two-port AXI read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

    localparam int AR_ADDR_W_MAX = 64;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Address is carried at its widest legal size; ports slice it down.
    typedef struct packed {
        logic [AR_ADDR_W_MAX-1:0] addr;
        logic [3:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic [2:0]               prot;
        logic [3:0]               cache;
    } ar_payload_t;

endpackage
`default_nettype wire

// File: rtl/axi_arb_rr.sv
`default_nettype none
// ============================================================================
// Module  : axi_arb_rr
// Brief   : Two-way grant pick. Round-robin when AXI_RD_ARB_ROUND_ROBIN_EN is
//           defined, otherwise fixed priority with requester 0 highest.
// Revision: 1.0 - initial release
// ============================================================================
module axi_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_done,
    input  logic       i_done_id,
    output logic       o_grant
);

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    // r_ptr names the requester favoured on the next contention.
    logic r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_done) begin
            r_ptr <= ~i_done_id;
        end
    end

    always_comb begin
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = r_ptr;
        end else begin
            o_grant = i_req[1] & ~i_req[0];
        end
    end
`else
    assign o_grant = i_req[1] & ~i_req[0];

    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_done, i_done_id};
`endif

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_rd_arbiter
// Brief   : Two-requester AXI3 read arbiter, one burst outstanding at a time.
//           Policy macro: AXI_RD_ARB_ROUND_ROBIN_EN (undefined = fixed priority).
// Revision: 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,

    input  logic                          s0_axi_arvalid,
    output logic                          s0_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [3:0]                    s0_axi_arlen,
    input  logic [2:0]                    s0_axi_arsize,
    input  logic [1:0]                    s0_axi_arburst,
    input  logic [2:0]                    s0_axi_arprot,
    input  logic [3:0]                    s0_axi_arcache,
    output logic                          s0_axi_rvalid,
    input  logic                          s0_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]                    s0_axi_rresp,
    output logic                          s0_axi_rlast,

    input  logic                          s1_axi_arvalid,
    output logic                          s1_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [3:0]                    s1_axi_arlen,
    input  logic [2:0]                    s1_axi_arsize,
    input  logic [1:0]                    s1_axi_arburst,
    input  logic [2:0]                    s1_axi_arprot,
    input  logic [3:0]                    s1_axi_arcache,
    output logic                          s1_axi_rvalid,
    input  logic                          s1_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]                    s1_axi_rresp,
    output logic                          s1_axi_rlast,

    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [3:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic [2:0]                    m_axi_arprot,
    output logic [3:0]                    m_axi_arcache,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,

    output logic                          grant_id,
    output logic                          busy,
    output logic                          err_len
);

    arb_state_e  r_state;
    logic        r_grant;
    logic [3:0]  r_len;
    logic [3:0]  r_beats;
    logic        r_err;

    ar_payload_t w_s0_ar;
    ar_payload_t w_s1_ar;
    ar_payload_t w_sel_ar;
    logic        w_in_addr;
    logic        w_in_data;
    logic        w_own0;
    logic        w_own1;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_done;
    logic        w_pick;

    always_comb begin
        w_s0_ar                              = '0;
        w_s0_ar.addr[C_M_AXI_ADDR_WIDTH-1:0] = s0_axi_araddr;
        w_s0_ar.len                          = s0_axi_arlen;
        w_s0_ar.size                         = s0_axi_arsize;
        w_s0_ar.burst                        = s0_axi_arburst;
        w_s0_ar.prot                         = s0_axi_arprot;
        w_s0_ar.cache                        = s0_axi_arcache;
        w_s1_ar                              = '0;
        w_s1_ar.addr[C_M_AXI_ADDR_WIDTH-1:0] = s1_axi_araddr;
        w_s1_ar.len                          = s1_axi_arlen;
        w_s1_ar.size                         = s1_axi_arsize;
        w_s1_ar.burst                        = s1_axi_arburst;
        w_s1_ar.prot                         = s1_axi_arprot;
        w_s1_ar.cache                        = s1_axi_arcache;
    end

    assign w_sel_ar  = r_grant ? w_s1_ar : w_s0_ar;
    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);
    assign w_own0    = ~r_grant;
    assign w_own1    = r_grant;

    // Downstream AR is live only in ADDR; payload is zeroed elsewhere.
    assign m_axi_arvalid = w_in_addr & (r_grant ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_araddr  = w_in_addr ? w_sel_ar.addr[C_M_AXI_ADDR_WIDTH-1:0] : '0;
    assign m_axi_arlen   = w_in_addr ? w_sel_ar.len   : '0;
    assign m_axi_arsize  = w_in_addr ? w_sel_ar.size  : '0;
    assign m_axi_arburst = w_in_addr ? w_sel_ar.burst : '0;
    assign m_axi_arprot  = w_in_addr ? w_sel_ar.prot  : '0;
    assign m_axi_arcache = w_in_addr ? w_sel_ar.cache : '0;
    assign s0_axi_arready = w_in_addr & w_own0 & m_axi_arready;
    assign s1_axi_arready = w_in_addr & w_own1 & m_axi_arready;

    assign m_axi_rready  = w_in_data & (r_grant ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rvalid = w_in_data & w_own0 & m_axi_rvalid;
    assign s0_axi_rdata  = (w_in_data & w_own0) ? m_axi_rdata : '0;
    assign s0_axi_rresp  = (w_in_data & w_own0) ? m_axi_rresp : RESP_OKAY;
    assign s0_axi_rlast  = w_in_data & w_own0 & m_axi_rlast;
    assign s1_axi_rvalid = w_in_data & w_own1 & m_axi_rvalid;
    assign s1_axi_rdata  = (w_in_data & w_own1) ? m_axi_rdata : '0;
    assign s1_axi_rresp  = (w_in_data & w_own1) ? m_axi_rresp : RESP_OKAY;
    assign s1_axi_rlast  = w_in_data & w_own1 & m_axi_rlast;

    assign w_ar_hs = m_axi_arvalid & m_axi_arready;
    assign w_r_hs  = m_axi_rvalid & m_axi_rready;
    assign w_done  = w_in_data & w_r_hs & m_axi_rlast;

    axi_arb_rr u_rr (
        .clk       (m_axi_aclk),
        .rst_n     (m_axi_aresetn),
        .i_req     ({s1_axi_arvalid, s0_axi_arvalid}),
        .i_done    (w_done),
        .i_done_id (r_grant),
        .o_grant   (w_pick)
    );

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_len   <= 4'd0;
            r_beats <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s0_axi_arvalid || s1_axi_arvalid) begin
                        r_grant <= w_pick;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_len   <= w_sel_ar.len;
                        r_beats <= 4'd0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_beats <= r_beats + 4'd1;
                        // Beats so far plus this one equal arlen+1 iff r_beats == arlen.
                        if (m_axi_rlast) begin
                            if (r_beats != r_len) begin
                                r_err <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign err_len  = r_err;

    logic w_unused;
    assign w_unused = &{1'b0, w_sel_ar.addr};

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32: AR address width on all ports.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 64: R data width on all ports.
REQ-003 m_axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-004 m_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 sN_axi_arvalid/arready, N=0,1  in/out  1  requester N AR handshake.
REQ-006 sN_axi_araddr/arlen[3:0]/arsize[2:0]/arburst[1:0]/arprot[2:0]/arcache[3:0]  in  various  requester N AR payload (AXI3).
REQ-007 sN_axi_rvalid/rready  out/in  1  requester N R handshake.
REQ-008 sN_axi_rdata/rresp[1:0]/rlast  out  DATA/2/1  requester N R payload.
REQ-009 m_axi_ar* (valid, ready, addr, len, size, burst, prot, cache)  out except ready  as REQ-005/006  shared downstream AR port.
REQ-010 m_axi_r* (valid, ready, data, resp, last)  in except ready  as REQ-007/008  shared downstream R port.
REQ-011 grant_id  out  1  index of current owner; valid when busy=1.
REQ-012 busy  out  1  1 in ADDR or DATA state.
REQ-013 err_len  out  1  sticky: beat count disagreed with arlen+1.

Function
REQ-014 FSM states are IDLE, ADDR and DATA; only one burst is outstanding at any time.
REQ-015 IDLE: when any sN_axi_arvalid=1, the arbiter registers the winner into grant_id and enters ADDR next cycle; it stays in IDLE otherwise.
REQ-016 ADDR: m_axi_ar* is driven combinationally from granted requester; granted sN_axi_arready=m_axi_arready; on m_axi_arvalid&m_axi_arready, the arbiter latches arlen and enters DATA.
REQ-017 Latency: request seen in IDLE at edge N; m_axi_arvalid=1 from cycle N+1.
REQ-018 DATA: granted sN_axi_r* = m_axi_r*; m_axi_rready = granted sN_axi_rready; a 4-bit beat counter increments per R handshake.
REQ-019 On R handshake with m_axi_rlast=1, the arbiter returns to IDLE next cycle; err_len is set if the beat count including this beat is not equal to latched arlen+1.
REQ-020 Non-granted requester: arready=0, rvalid=0, rdata/rresp/rlast=0, at all times.
REQ-021 Outside ADDR: m_axi_arvalid=0 and m_axi_ar* payload=0; outside DATA: m_axi_rready=0.
REQ-022 R beats arriving in IDLE or ADDR are not accepted (rready=0) and are not routed to either requester.
REQ-023 Simultaneous requests resolve per REQ-030/031; a request arriving mid-burst waits and is not lost.
REQ-024 Dropping sN_axi_arvalid before handshake is an AXI violation and is unsupported; no recovery is required.

Reset
REQ-025 Asserting m_axi_aresetn low immediately forces state=IDLE, grant_id=0, busy=0, err_len=0, beat counter=0, and the round-robin pointer to 0.
REQ-026 During reset, every valid/ready output is 0.
REQ-027 Reset mid-burst abandons the burst silently; after release the block resumes from IDLE.
REQ-028 Reset release is synchronised externally; the block does not add a synchroniser.

Configuration
REQ-029 Macro AXI_RD_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-030 Defined: round-robin; on contention, the requester not granted last wins; the pointer updates when the burst completes (REQ-019).
REQ-031 Undefined: fixed priority; requester 0 always wins contention; the pointer logic is removed.

Structure
REQ-032 The shared package axi_arb_pkg holds the FSM state enum, the AR payload struct (addr/len/size/burst/prot/cache), and the AXI3 constants RESP_OKAY and BURST_INCR.
REQ-033 One sub-module, axi_arb_rr (the 2-way grant pick plus pointer), is instantiated from IDLE logic; it is compiled to fixed priority without the macro.

Verification
REQ-034 Single request: s0 issues araddr=0x1000, arlen=3 -> m_axi_arvalid at next cycle with the same payload; 4 beats are routed to s0; IDLE after rlast; err_len=0.
REQ-035 Contention with macro defined: s0 and s1 request continuously -> grants alternate 0,1,0,1 over 4 bursts; s1 R channel is silent during s0 bursts.
REQ-036 Contention without macro: the same stimulus -> all 4 grants go to s0 while s0 keeps requesting; s1 is granted only after s0 drops arvalid.
REQ-037 Length error: arlen=3 with rlast on beat 2 -> err_len=1 and stays 1 across later good bursts until reset.
REQ-038 Backpressure: s1 rready toggles 1,0,1,0 during an arlen=7 burst -> m_axi_rready mirrors it; 8 beats are delivered in order with no loss.
REQ-039 Reset in DATA after beat 2 of arlen=7 -> all valids are 0 the same cycle; busy=0; a new s0 request after release is served normally.
